// File: rtl/bsg_nasti_client.sv
// NASTI slave endpoint: serialises single-beat AW/W and AR requests into one
// tunnel request stream and turns tunnel responses back into B/R beats.
module bsg_nasti_client #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 5,
  parameter int max_out_p    = 4
) (
  input  logic                                                             clk_i,
  input  logic                                                             reset_i,
  input  logic                                                             nasti_aw_valid_i,
  input  logic [addr_width_p-1:0]                                          nasti_aw_addr_i,
  input  logic [id_width_p-1:0]                                            nasti_aw_id_i,
  output logic                                                             nasti_aw_ready_o,
  input  logic                                                             nasti_w_valid_i,
  input  logic [data_width_p-1:0]                                          nasti_w_data_i,
  input  logic [data_width_p/8-1:0]                                        nasti_w_strb_i,
  input  logic                                                             nasti_w_last_i,
  output logic                                                             nasti_w_ready_o,
  output logic                                                             nasti_b_valid_o,
  output logic [id_width_p-1:0]                                            nasti_b_id_o,
  output logic [1:0]                                                       nasti_b_resp_o,
  input  logic                                                             nasti_b_ready_i,
  input  logic                                                             nasti_ar_valid_i,
  input  logic [addr_width_p-1:0]                                          nasti_ar_addr_i,
  input  logic [id_width_p-1:0]                                            nasti_ar_id_i,
  output logic                                                             nasti_ar_ready_o,
  output logic                                                             nasti_r_valid_o,
  output logic [data_width_p-1:0]                                          nasti_r_data_o,
  output logic [id_width_p-1:0]                                            nasti_r_id_o,
  output logic [1:0]                                                       nasti_r_resp_o,
  output logic                                                             nasti_r_last_o,
  input  logic                                                             nasti_r_ready_i,
  output logic                                                             req_valid_o,
  output logic [1+id_width_p+addr_width_p+data_width_p/8+data_width_p-1:0] req_data_o,
  input  logic                                                             req_yumi_i,
  input  logic                                                             resp_valid_i,
  input  logic [1+id_width_p+2+data_width_p-1:0]                           resp_data_i,
  output logic                                                             resp_yumi_o
);

  localparam int strb_w_lp = data_width_p/8;
  localparam int resp_w_lp = 1+id_width_p+2+data_width_p;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;

  localparam logic [3:0] MAX_OUT = 4'(max_out_p);

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic                    r_last_w;
  logic [3:0]              r_count;
  logic                    r_op;
  logic [id_width_p-1:0]   r_id;
  logic [addr_width_p-1:0] r_addr;
  logic [strb_w_lp-1:0]    r_strb;
  logic [data_width_p-1:0] r_data;

  logic                    r_b_valid;
  logic                    r_r_valid;
  logic [id_width_p-1:0]   r_rsp_id;
  logic [1:0]              r_rsp_code;
  logic [data_width_p-1:0] r_rsp_data;

  logic w_idle, w_can, w_aw_grant, w_ar_grant, w_w_accept;
  logic w_inc, w_dec, w_drain, w_empty, w_rsp_load;

  logic                    w_rsp_op;
  logic [id_width_p-1:0]   w_rsp_id;
  logic [1:0]              w_rsp_code;
  logic [data_width_p-1:0] w_rsp_data;

  assign w_rsp_op   = resp_data_i[resp_w_lp-1];
  assign w_rsp_id   = resp_data_i[data_width_p+2 +: id_width_p];
  assign w_rsp_code = resp_data_i[data_width_p +: 2];
  assign w_rsp_data = resp_data_i[data_width_p-1:0];

  // Round-robin on ties: whichever channel won last time yields the next tie.
  assign w_idle     = (r_state == IDLE) & ~reset_i;
  assign w_can      = (r_count < MAX_OUT);
  assign w_aw_grant = w_idle & w_can & nasti_aw_valid_i & (~nasti_ar_valid_i | ~r_last_w);
  assign w_ar_grant = w_idle & w_can & nasti_ar_valid_i & ~w_aw_grant;
  assign w_w_accept = (r_state == W_WAIT) & ~reset_i & nasti_w_valid_i;

  assign w_inc      = (r_state == SEND) & req_yumi_i;
  assign w_drain    = (r_b_valid & nasti_b_ready_i) | (r_r_valid & nasti_r_ready_i);
  assign w_dec      = w_drain;
  assign w_empty    = ~r_b_valid & ~r_r_valid;
  assign w_rsp_load = resp_valid_i & ~reset_i & (w_empty | w_drain);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_grant)      w_state_next = W_WAIT;
        else if (w_ar_grant) w_state_next = SEND;
      end
      W_WAIT: if (w_w_accept) w_state_next = SEND;
      SEND:   if (req_yumi_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_last_w  <= 1'b0;
      r_count   <= 4'd0;
      r_b_valid <= 1'b0;
      r_r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_aw_grant | w_ar_grant) r_last_w <= w_aw_grant;
      if (w_inc & ~w_dec)      r_count <= r_count + 4'd1;
      else if (~w_inc & w_dec) r_count <= r_count - 4'd1;
      if (w_rsp_load) begin
        r_b_valid <= w_rsp_op;
        r_r_valid <= ~w_rsp_op;
      end else if (w_drain) begin
        r_b_valid <= 1'b0;
        r_r_valid <= 1'b0;
      end
    end
  end

  // Payload registers need no reset; the valid flags above qualify them.
  always_ff @(posedge clk_i) begin
    if (w_aw_grant) begin
      r_op   <= 1'b1;
      r_id   <= nasti_aw_id_i;
      r_addr <= nasti_aw_addr_i;
    end else if (w_ar_grant) begin
      r_op   <= 1'b0;
      r_id   <= nasti_ar_id_i;
      r_addr <= nasti_ar_addr_i;
      r_strb <= '0;
      r_data <= '0;
    end
    if (w_w_accept) begin
      r_strb <= nasti_w_strb_i;
      r_data <= nasti_w_data_i;
    end
    if (w_rsp_load) begin
      r_rsp_id   <= w_rsp_id;
      r_rsp_code <= w_rsp_code;
      r_rsp_data <= w_rsp_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (w_w_accept) assert (nasti_w_last_i);
      if (w_rsp_load) assert (r_count != 4'd0);
      if (w_inc && !w_dec) assert (r_count != 4'hF);
    end
  end

  assign nasti_aw_ready_o = w_aw_grant;
  assign nasti_ar_ready_o = w_ar_grant;
  assign nasti_w_ready_o  = (r_state == W_WAIT) & ~reset_i;
  assign req_valid_o      = (r_state == SEND) & ~reset_i;
  assign req_data_o       = {r_op, r_id, r_addr, r_strb, r_data};
  assign resp_yumi_o      = w_rsp_load;

  assign nasti_b_valid_o  = r_b_valid;
  assign nasti_b_id_o     = r_rsp_id;
  assign nasti_b_resp_o   = r_rsp_code;
  assign nasti_r_valid_o  = r_r_valid;
  assign nasti_r_data_o   = r_rsp_data;
  assign nasti_r_id_o     = r_rsp_id;
  assign nasti_r_resp_o   = r_rsp_code;
  assign nasti_r_last_o   = r_r_valid;

endmodule

// File: tb/tb_bsg_nasti_client.sv
// Bench for bsg_nasti_client: directed scenarios plus a randomized phase,
// checked against a queue model of the tunnel's outstanding transactions.
module tb_bsg_nasti_client;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int IW    = 5;
  localparam int SW    = DW/8;
  localparam int MAXO  = 4;
  localparam int REQW  = 1+IW+AW+SW+DW;
  localparam int RESPW = 1+IW+2+DW;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            aw_valid, aw_ready, w_valid, w_last, w_ready;
  logic [AW-1:0]   aw_addr, ar_addr;
  logic [IW-1:0]   aw_id, ar_id, b_id, r_id;
  logic [DW-1:0]   w_data, r_data;
  logic [SW-1:0]   w_strb;
  logic            b_valid, b_ready, ar_valid, ar_ready, r_valid, r_last, r_ready;
  logic [1:0]      b_resp, r_resp;
  logic            req_valid, req_yumi, resp_valid, resp_yumi;
  logic [REQW-1:0] req_data;
  logic [RESPW-1:0] resp_data;

  int n_checks = 0;
  int n_fails  = 0;
  int outstanding = 0;
  bit            op_q[$];
  logic [IW-1:0] id_q[$];

  always #5 clk = ~clk;

  bsg_nasti_client #(.addr_width_p(AW), .data_width_p(DW), .id_width_p(IW), .max_out_p(MAXO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .nasti_aw_valid_i(aw_valid), .nasti_aw_addr_i(aw_addr), .nasti_aw_id_i(aw_id),
    .nasti_aw_ready_o(aw_ready),
    .nasti_w_valid_i(w_valid), .nasti_w_data_i(w_data), .nasti_w_strb_i(w_strb),
    .nasti_w_last_i(w_last), .nasti_w_ready_o(w_ready),
    .nasti_b_valid_o(b_valid), .nasti_b_id_o(b_id), .nasti_b_resp_o(b_resp),
    .nasti_b_ready_i(b_ready),
    .nasti_ar_valid_i(ar_valid), .nasti_ar_addr_i(ar_addr), .nasti_ar_id_i(ar_id),
    .nasti_ar_ready_o(ar_ready),
    .nasti_r_valid_o(r_valid), .nasti_r_data_o(r_data), .nasti_r_id_o(r_id),
    .nasti_r_resp_o(r_resp), .nasti_r_last_o(r_last), .nasti_r_ready_i(r_ready),
    .req_valid_o(req_valid), .req_data_o(req_data), .req_yumi_i(req_yumi),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data), .resp_yumi_o(resp_yumi)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REQW-1:0] pack_req(input bit op, input logic [IW-1:0] id,
      input logic [AW-1:0] addr, input logic [SW-1:0] strb, input logic [DW-1:0] data);
    return {op, id, addr, strb, data};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic samp(); @(negedge clk); endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_aw_ready"},  aw_ready,  0);
    chk({tag, "_ar_ready"},  ar_ready,  0);
    chk({tag, "_w_ready"},   w_ready,   0);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_b_valid"},   b_valid,   0);
    chk({tag, "_r_valid"},   r_valid,   0);
    chk({tag, "_r_last"},    r_last,    0);
    chk({tag, "_resp_yumi"}, resp_yumi, 0);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [IW-1:0] id);
    tick(); ar_valid = 1; ar_addr = addr; ar_id = id;
    samp(); chk("rd_ar_ready", ar_ready, 1); chk("rd_aw_ready", aw_ready, 0);
    tick(); ar_valid = 0;
    samp(); chk("rd_req_valid", req_valid, 1);
    chk("rd_req_data", req_data, pack_req(0, id, addr, '0, '0));
    req_yumi = 1;
    tick(); req_yumi = 0;
    outstanding++; op_q.push_back(0); id_q.push_back(id);
    $display("read  issued id=%0h addr=%08h outstanding=%0d", id, addr, outstanding);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [IW-1:0] id,
      input logic [DW-1:0] data, input logic [SW-1:0] strb, input int gap, input bit early);
    tick(); aw_valid = 1; aw_addr = addr; aw_id = id;
    w_data = data; w_strb = strb; w_valid = early;
    samp(); chk("wr_aw_ready", aw_ready, 1); chk("wr_w_held", w_ready, 0);
    tick(); aw_valid = 0; w_valid = (gap == 0);
    samp(); chk("wr_w_ready", w_ready, 1);
    for (int g = 0; g < gap; g++) begin
      tick(); w_valid = (g == gap-1);
      samp(); chk("wr_w_ready_wait", w_ready, 1); chk("wr_no_req", req_valid, 0);
    end
    tick(); w_valid = 0;
    samp(); chk("wr_req_valid", req_valid, 1);
    chk("wr_req_data", req_data, pack_req(1, id, addr, strb, data));
    req_yumi = 1;
    tick(); req_yumi = 0;
    outstanding++; op_q.push_back(1); id_q.push_back(id);
    $display("write issued id=%0h addr=%08h data=%016h strb=%02h outstanding=%0d",
             id, addr, data, strb, outstanding);
  endtask

  // Plays the tunnel: returns the oldest outstanding transaction's response.
  task automatic send_resp(input logic [1:0] code, input logic [DW-1:0] data, input int delay);
    bit op; logic [IW-1:0] id;
    op = op_q.pop_front(); id = id_q.pop_front();
    tick(); resp_valid = 1; resp_data = {op, id, code, data};
    samp(); chk("rsp_yumi", resp_yumi, 1);
    tick(); resp_valid = 0;
    for (int d = 0; d <= delay; d++) begin
      samp();
      chk("rsp_b_valid", b_valid, op); chk("rsp_r_valid", r_valid, !op);
      if (op) begin
        chk("rsp_b_id", b_id, id); chk("rsp_b_resp", b_resp, code);
      end else begin
        chk("rsp_r_data", r_data, data); chk("rsp_r_id", r_id, id);
        chk("rsp_r_resp", r_resp, code); chk("rsp_r_last", r_last, 1);
      end
      if (d == delay) begin
        if (op) b_ready = 1; else r_ready = 1;
      end
      tick();
    end
    b_ready = 0; r_ready = 0;
    samp(); chk("rsp_b_drained", b_valid, 0); chk("rsp_r_drained", r_valid, 0);
    outstanding--;
    $display("resp  op=%0d id=%0h resp=%0d data=%016h outstanding=%0d", op, id, code, data, outstanding);
  endtask

  task automatic drain_all();
    while (op_q.size() > 0)
      send_resp(2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 2));
  endtask

  task automatic pulse_reset();
    tick(); reset_i = 1;
    tick(); reset_i = 0;
    outstanding = 0; op_q.delete(); id_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit            exp_w [4];
    logic [AW-1:0] a5;
    logic [IW-1:0] i5, id1, id2;
    logic [DW-1:0] d1, d2;
    bit            op1;

    exp_w = '{1, 0, 1, 0};
    reset_i = 1; w_last = 1;
    aw_valid = 1; ar_valid = 1; w_valid = 1; resp_valid = 1;
    aw_addr = '0; aw_id = '0; ar_addr = '0; ar_id = '0; w_data = '0; w_strb = '0;
    b_ready = 0; r_ready = 0; req_yumi = 0; resp_data = '0;

    // Reset state, with valids driven to show they are ignored.
    tick(); samp(); chk_idle("rst");
    tick(); reset_i = 0; aw_valid = 0; ar_valid = 0; w_valid = 0; resp_valid = 0;
    samp(); chk_idle("post_rst");

    // Directed read and write.
    do_read(32'h8000_0040, 5'd3);
    send_resp(2'd0, 64'hDEADBEEF_CAFEF00D, 0);
    do_write(32'h0000_0100, 5'd7, 64'h11223344_55667788, 8'h0F, 1, 0);
    send_resp(2'd0, {$urandom, $urandom}, 0);

    // Arbitration with both channels always pending: W, R, W, R, then throttled.
    pulse_reset();
    tick(); aw_valid = 1; ar_valid = 1; w_valid = 1; w_strb = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      aw_addr = $urandom; aw_id = IW'(k); ar_addr = $urandom; ar_id = IW'(k + 8);
      w_data = {$urandom, $urandom};
      samp(); chk("arb_aw_ready", aw_ready, exp_w[k]); chk("arb_ar_ready", ar_ready, !exp_w[k]);
      if (exp_w[k]) begin
        tick(); samp(); chk("arb_w_ready", w_ready, 1);
      end
      tick(); samp(); chk("arb_req_valid", req_valid, 1);
      chk("arb_req_data", req_data, exp_w[k] ? pack_req(1, aw_id, aw_addr, w_strb, w_data)
                                             : pack_req(0, ar_id, ar_addr, '0, '0));
      req_yumi = 1;
      tick(); req_yumi = 0;
      outstanding++; op_q.push_back(exp_w[k]); id_q.push_back(exp_w[k] ? aw_id : ar_id);
      $display("arb   grant %0d -> %s", k, exp_w[k] ? "W" : "R");
    end
    samp(); chk("arb_full_aw", aw_ready, 0); chk("arb_full_ar", ar_ready, 0);
    tick(); aw_valid = 0; ar_valid = 0; w_valid = 0;
    drain_all();

    // Throttle at max outstanding; one R handshake reopens AR the next cycle.
    for (int k = 0; k < MAXO; k++) do_read($urandom, IW'($urandom));
    a5 = $urandom; i5 = IW'($urandom);
    tick(); ar_valid = 1; ar_addr = a5; ar_id = i5;
    samp(); chk("thr_block0", ar_ready, 0);
    tick(); samp(); chk("thr_block1", ar_ready, 0);
    op1 = op_q.pop_front(); id1 = id_q.pop_front(); d1 = {$urandom, $urandom};
    tick(); resp_valid = 1; resp_data = {op1, id1, 2'b00, d1};
    samp(); chk("thr_yumi", resp_yumi, 1); chk("thr_block2", ar_ready, 0);
    tick(); resp_valid = 0;
    samp(); chk("thr_r_data", r_data, d1); chk("thr_block3", ar_ready, 0);
    r_ready = 1;
    tick(); r_ready = 0; outstanding--;
    samp(); chk("thr_release", ar_ready, 1);
    tick(); ar_valid = 0;
    samp(); chk("thr_req_valid", req_valid, 1); chk("thr_req_data", req_data, pack_req(0, i5, a5, '0, '0));
    req_yumi = 1;
    tick(); req_yumi = 0; outstanding++; op_q.push_back(0); id_q.push_back(i5);
    $display("throttle released, outstanding=%0d", outstanding);

    // Backpressure on R with a second response waiting.
    void'(op_q.pop_front()); id1 = id_q.pop_front();
    void'(op_q.pop_front()); id2 = id_q.pop_front();
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    tick(); resp_valid = 1; resp_data = {1'b0, id1, 2'b01, d1};
    samp(); chk("bp_yumi1", resp_yumi, 1);
    tick(); resp_data = {1'b0, id2, 2'b10, d2};
    for (int c = 0; c < 5; c++) begin
      samp(); chk("bp_hold_yumi", resp_yumi, 0); chk("bp_hold_valid", r_valid, 1);
      chk("bp_hold_data", r_data, d1); chk("bp_hold_id", r_id, id1);
      tick();
    end
    r_ready = 1;
    samp(); chk("bp_swap_yumi", resp_yumi, 1); chk("bp_first_data", r_data, d1);
    tick(); resp_valid = 0;
    samp(); chk("bp_second_valid", r_valid, 1); chk("bp_second_data", r_data, d2);
    chk("bp_second_id", r_id, id2); chk("bp_second_resp", r_resp, 2'b10);
    tick(); r_ready = 0; outstanding -= 2;
    samp(); chk("bp_empty", r_valid, 0);
    $display("backpressure done, outstanding=%0d", outstanding);
    drain_all();

    // Reset while waiting for W.
    tick(); aw_valid = 1; aw_addr = $urandom; aw_id = 5'd9;
    tick(); aw_valid = 0;
    samp(); chk("rw_in_wwait", w_ready, 1);
    reset_i = 1;
    tick(); reset_i = 0;
    samp(); chk_idle("rst_wwait");

    // Reset while in SEND with a response held in the output register.
    do_read($urandom, 5'd4);
    tick(); ar_valid = 1; ar_addr = $urandom; ar_id = 5'd5;
    tick(); ar_valid = 0; resp_valid = 1; resp_data = {1'b0, 5'd4, 2'b00, 64'h1};
    samp(); chk("rs_req_valid", req_valid, 1); chk("rs_yumi", resp_yumi, 1);
    tick(); resp_valid = 0;
    samp(); chk("rs_r_held", r_valid, 1);
    reset_i = 1;
    tick(); reset_i = 0;
    outstanding = 0; op_q.delete(); id_q.delete();
    samp(); chk_idle("rst_send");

    // Count restarted at zero: a full window is accepted, one more is not.
    for (int k = 0; k < MAXO; k++) do_read($urandom, IW'($urandom));
    tick(); ar_valid = 1;
    samp(); chk("post_rst_full", ar_ready, 0);
    tick(); ar_valid = 0;
    drain_all();

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      if (outstanding < MAXO && (outstanding == 0 || $urandom_range(0, 1) == 1)) begin
        if ($urandom_range(0, 1) == 1)
          do_write($urandom, IW'($urandom), {$urandom, $urandom}, SW'($urandom),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        else
          do_read($urandom, IW'($urandom));
      end else begin
        send_resp(2'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom_range(0, 2));
      end
    end
    drain_all();

    tick(); samp(); chk_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
